hilo_regs: RTL and testbench

HILO_REGS -- requirements
Module: hilo_regs

---
 rtl/hilo_pkg.sv | 14 +
 rtl/hilo_regs.sv | 110 +++++++++++
 tb/tb_hilo_regs.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register block.
package hilo_pkg;

    localparam int WORD_W = 32;

    localparam logic RD_SEL_LO = 1'b0;
    localparam logic RD_SEL_HI = 1'b1;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural registers: multiply/divide results land one cycle after
// capture, MTHI/MTLO write immediately, and MFHI/MFLO reads forward same-cycle updates.
module hilo_regs
    import hilo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mul_valid,
    input  logic [WORD_W-1:0] mul_hi,
    input  logic [WORD_W-1:0] mul_lo,
    input  logic              div_valid,
    input  logic [WORD_W-1:0] div_q,
    input  logic [WORD_W-1:0] div_r,
    input  logic              mthi_valid,
    input  logic              mtlo_valid,
    input  logic [WORD_W-1:0] mt_data,
    input  logic              rd_req,
    input  logic              rd_sel,
    output logic              stall,
    output logic              rd_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    hilo_state_e       state_q, state_d;
    logic [WORD_W-1:0] stage_hi_q, stage_lo_q;
    logic [WORD_W-1:0] hi_q, lo_q;
    logic [WORD_W-1:0] hi_d, lo_d;
    logic              rd_valid_q;
    logic [WORD_W-1:0] rd_data_q;

    logic              capture;
    logic              commit;
    logic              rd_accept;
    logic [WORD_W-1:0] cap_hi, cap_lo;

    // mul wins when both units present a result in the same cycle
    assign capture = mul_valid || div_valid;
    assign cap_hi  = mul_valid ? mul_hi : div_r;
    assign cap_lo  = mul_valid ? mul_lo : div_q;
    assign commit  = (state_q == PENDING);

    assign stall     = rst_n && rd_req && capture;
    assign rd_accept = rd_req && !capture;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = capture ? PENDING : IDLE;
            PENDING: state_d = capture ? PENDING : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_hi_q <= '0;
            stage_lo_q <= '0;
        end else if (capture) begin
            stage_hi_q <= cap_hi;
            stage_lo_q <= cap_lo;
        end
    end

    // MT writes take priority over the half they target in a commit cycle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = stage_hi_q;
            lo_d = stage_lo_q;
        end
        if (mthi_valid) hi_d = mt_data;
        if (mtlo_valid) lo_d = mt_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // read result reflects this cycle's commit and MT write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept)
                rd_data_q <= (rd_sel == RD_SEL_HI) ? hi_d : lo_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_regs.sv
// Self-checking bench for hilo_regs: directed vector table, reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_hilo_regs;
    import hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_valid, div_valid, mthi_valid, mtlo_valid, rd_req, rd_sel;
    logic [31:0] mul_hi, mul_lo, div_q, div_r, mt_data;
    logic        stall, rd_valid;
    logic [31:0] rd_data, hi, lo;

    int checks = 0;
    int failures = 0;

    hilo_regs dut (
        .clk(clk), .rst_n(rst_n),
        .mul_valid(mul_valid), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_valid(div_valid), .div_q(div_q), .div_r(div_r),
        .mthi_valid(mthi_valid), .mtlo_valid(mtlo_valid), .mt_data(mt_data),
        .rd_req(rd_req), .rd_sel(rd_sel),
        .stall(stall), .rd_valid(rd_valid), .rd_data(rd_data),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mul_v;
        logic [31:0] m_hi, m_lo;
        logic        div_v;
        logic [31:0] d_q, d_r;
        logic        mthi, mtlo;
        logic [31:0] mt;
        logic        rreq, rsel;
        logic        e_stall;
        logic [31:0] e_hi, e_lo;
        logic        e_rdv;
        logic [31:0] e_rdd;
    } vec_t;

    typedef struct {
        logic [63:0] v;
        int          due;
    } pend_t;

    // reference model: architectural view plus a queue of results due at a future cycle
    pend_t       pend[$];
    logic [31:0] m_hi, m_lo, m_rdd;
    logic        m_rdv;
    int          cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        m_hi = 0; m_lo = 0; m_rdd = 0; m_rdv = 0; cyc = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nh, nl;
        logic        acc;
        nh = m_hi; nl = m_lo;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            nh = pend[0].v[63:32];
            nl = pend[0].v[31:0];
            void'(pend.pop_front());
        end
        if (mthi_valid) nh = mt_data;
        if (mtlo_valid) nl = mt_data;
        acc = rd_req && !(mul_valid || div_valid);
        m_rdv = acc;
        if (acc) m_rdd = rd_sel ? nh : nl;
        if (mul_valid)      pend.push_back('{v: {mul_hi, mul_lo}, due: cyc + 1});
        else if (div_valid) pend.push_back('{v: {div_r, div_q},  due: cyc + 1});
        m_hi = nh; m_lo = nl;
        cyc++;
    endtask

    task automatic idle_inputs();
        mul_valid = 0; mul_hi = 0; mul_lo = 0;
        div_valid = 0; div_q = 0; div_r = 0;
        mthi_valid = 0; mtlo_valid = 0; mt_data = 0;
        rd_req = 0; rd_sel = 0;
    endtask

    task automatic drive(input vec_t t);
        mul_valid = t.mul_v; mul_hi = t.m_hi; mul_lo = t.m_lo;
        div_valid = t.div_v; div_q = t.d_q; div_r = t.d_r;
        mthi_valid = t.mthi; mtlo_valid = t.mtlo; mt_data = t.mt;
        rd_req = t.rreq; rd_sel = t.rsel;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tbl[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // stall must be forced low during reset even with a read colliding with a result
        idle_inputs();
        rst_n = 0;
        rd_req = 1; mul_valid = 1;
        model_reset();
        #3;
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_rdv", {31'b0, rd_valid}, 0);
        chk("reset_rdd", rd_data, 0);
        chk("reset_stall", {31'b0, stall}, 0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1;

        //            mul hi           lo            div q        r            mthi mtlo mt           rq rs stl hi           lo           rdv rdd
        tbl[0]  = '{1, 32'h1,        32'hFFFF_FFFE, 0, 0,        0,        0, 0, 0,            0, 0, 0, 32'h0,        32'h0,        0, 32'h0};
        tbl[1]  = '{0, 0,            0,             0, 0,        0,        0, 0, 0,            0, 0, 0, 32'h1,        32'hFFFF_FFFE, 0, 32'h0};
        tbl[2]  = '{1, 32'h1234_5678, 32'h0,        0, 0,        0,        0, 0, 0,            1, 1, 1, 32'h1,        32'hFFFF_FFFE, 0, 32'h0};
        tbl[3]  = '{0, 0,            0,             0, 0,        0,        0, 0, 0,            1, 1, 0, 32'h1234_5678, 32'h0,        1, 32'h1234_5678};
        tbl[4]  = '{0, 0,            0,             1, 32'h7,    32'h3,    0, 0, 0,            0, 0, 0, 32'h1234_5678, 32'h0,        0, 32'h1234_5678};
        tbl[5]  = '{0, 0,            0,             0, 0,        0,        0, 1, 32'hAAAA_0000, 0, 0, 0, 32'h3,        32'hAAAA_0000, 0, 32'h1234_5678};
        tbl[6]  = '{1, 32'h9,        32'h11,        0, 0,        0,        1, 0, 32'h5,        0, 0, 0, 32'h5,        32'hAAAA_0000, 0, 32'h1234_5678};
        tbl[7]  = '{0, 0,            0,             0, 0,        0,        0, 0, 0,            0, 0, 0, 32'h9,        32'h11,       0, 32'h1234_5678};
        tbl[8]  = '{1, 32'hA1,       32'hA2,        1, 32'hD1,   32'hD2,   0, 0, 0,            0, 0, 0, 32'h9,        32'h11,       0, 32'h1234_5678};
        tbl[9]  = '{0, 0,            0,             0, 0,        0,        0, 0, 0,            1, 0, 0, 32'hA1,       32'hA2,       1, 32'hA2};
        tbl[10] = '{0, 0,            0,             0, 0,        0,        1, 0, 32'hBEEF,     1, 1, 0, 32'hBEEF,     32'hA2,       1, 32'hBEEF};

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
            tick();
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].e_hi);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].e_lo);
            chk($sformatf("vec%0d_rdv", i), {31'b0, rd_valid}, {31'b0, tbl[i].e_rdv});
            chk($sformatf("vec%0d_rdd", i), rd_data, tbl[i].e_rdd);
        end

        // reset while a result is staged: it must never reach HI/LO
        @(negedge clk);
        idle_inputs();
        mul_valid = 1; mul_hi = 32'hFFFF_FFFF; mul_lo = 32'h5555_5555;
        tick();
        chk("pend_state", 32'(dut.state_q), 32'(PENDING));
        @(negedge clk);
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        chk("rstpend_hi", hi, 0);
        chk("rstpend_lo", lo, 0);
        chk("rstpend_rdv", {31'b0, rd_valid}, 0);
        chk("rstpend_rdd", rd_data, 0);
        chk("rstpend_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tick();
            chk("postrst_hi", hi, 0);
            chk("postrst_lo", lo, 0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            mul_valid  = ($urandom_range(0, 3) == 0);
            div_valid  = ($urandom_range(0, 3) == 0);
            mthi_valid = ($urandom_range(0, 4) == 0);
            mtlo_valid = ($urandom_range(0, 4) == 0);
            rd_req     = ($urandom_range(0, 1) == 0);
            rd_sel     = 1'($urandom_range(0, 1));
            mul_hi = $urandom; mul_lo = $urandom;
            div_q  = $urandom; div_r  = $urandom;
            mt_data = $urandom;
            #1;
            chk("rnd_stall", {31'b0, stall}, {31'b0, rd_req && (mul_valid || div_valid)});
            tick();
            chk("rnd_hi", hi, m_hi);
            chk("rnd_lo", lo, m_lo);
            chk("rnd_rdv", {31'b0, rd_valid}, {31'b0, m_rdv});
            chk("rnd_rdd", rd_data, m_rdd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
